// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with a single-entry load/store response stage.
// Loads and stores are checked for alignment and range; errored requests touch nothing.
module data_mem_lsu #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [15:0]       err_count
);
    localparam int IDX_W = $clog2(DEPTH);
    // One bit wider than both the address and DEPTH so addr + size never wraps.
    localparam int CMP_W = ((ADDR_W > 17) ? ADDR_W : 17) + 1;

    typedef logic [7:0] mem_t [DEPTH];
    typedef enum logic {IDLE, RESP} state_t;
    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } rsp_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = 8'(i);
        return m;
    endfunction

    // Power-up contents come from the declaration; reset never touches the array.
    mem_t mem = init_mem();

    state_t            state_q, state_d;
    rsp_t              rsp_q, rsp_d;
    logic              accept, misaligned, out_of_range, err, sgn;
    logic [3:0]        nbytes;
    logic [2:0]        amask;
    logic [CMP_W-1:0]  end_addr;
    logic [IDX_W-1:0]  idx;
    logic [63:0]       raw, ext;

    assign rsp_valid = (state_q == RESP);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    assign nbytes       = 4'd1 << req_size;
    assign amask        = 3'(nbytes - 4'd1);
    assign misaligned   = (req_addr[2:0] & amask) != 3'd0;
    assign end_addr     = CMP_W'(req_addr) + CMP_W'(nbytes);
    assign out_of_range = end_addr > CMP_W'(DEPTH);
    assign err          = misaligned || out_of_range;
    assign idx          = req_addr[IDX_W-1:0];
    assign sgn          = !req_unsigned;

    always_comb begin
        raw = '0;
        for (int k = 0; k < 8; k++)
            if (4'(k) < nbytes) raw[8*k +: 8] = mem[idx + IDX_W'(k)];
    end

    always_comb begin
        ext = raw;
        unique case (req_size)
            2'd0:    ext = {{56{sgn & raw[7]}},  raw[7:0]};
            2'd1:    ext = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    ext = {{32{sgn & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
        rsp_d.err   = err;
        rsp_d.rdata = (err || req_we) ? 64'd0 : ext;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (rsp_ready) state_d = accept ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rsp_q     <= '0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_q <= rsp_d;
                if (err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
        end
    end

    // Reset is sampled here too so an accept coinciding with reset cannot write.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err && !reset)
            for (int k = 0; k < 8; k++)
                if (4'(k) < nbytes) mem[idx + IDX_W'(k)] <= req_wdata[8*k +: 8];
    end

    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed and randomized checks of data_mem_lsu against a byte-array reference model.
module tb_data_mem_lsu;
    localparam int ADDR_W = 64;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [63:0]       rsp_rdata;
    logic [15:0]       err_count;

    int errors = 0;
    int checks = 0;
    byte unsigned rmem [DEPTH];
    int exp_cnt = 0;

    data_mem_lsu #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: apply one accepted request to the byte array, return the expected response.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         output logic [63:0] er, output logic ee);
        longint unsigned a = addr;
        longint unsigned v = 0;
        int nb = 1 << sz;
        ee = (a % longint'(nb) != 0) || (a > longint'(DEPTH - nb));
        er = 64'd0;
        if (ee) begin
            if (exp_cnt < 65535) exp_cnt++;
        end else if (we) begin
            for (int k = 0; k < nb; k++) rmem[a + longint'(k)] = wd[8*k +: 8];
        end else begin
            for (int k = 0; k < nb; k++) v = v | (longint'(rmem[a + longint'(k)]) << (8*k));
            if (!uns && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
            er = v;
        end
    endtask

    // Present a request with rsp_ready=1; it is accepted at the next edge and checked after it.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd);
        logic [63:0] er;
        logic        ee;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
        model(we, sz, uns, addr, wd, er, ee);
        #1;
        chk("req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_err",   64'(rsp_err),   64'(ee));
        chk("rsp_rdata", rsp_rdata, er);
        chk("err_count", 64'(err_count), 64'(exp_cnt));
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        for (int i = 0; i < DEPTH; i++) rmem[i] = 8'(i);
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        #3;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_err",   64'(rsp_err), 64'd0);
        chk("rst_cnt",   64'(err_count), 64'd0);
        @(negedge clk); reset = 1'b0;

        issue(1'b0, 2'd3, 1'b0, 64'h0, 64'h0);
        chk("init_pattern", rsp_rdata, 64'h0706050403020100);
        issue(1'b0, 2'd0, 1'b0, 64'h80, 64'h0);
        chk("lb_signed", rsp_rdata, 64'hFFFFFFFFFFFFFF80);
        issue(1'b0, 2'd0, 1'b1, 64'h80, 64'h0);
        chk("lb_unsigned", rsp_rdata, 64'h0000000000000080);
        issue(1'b0, 2'd1, 1'b0, 64'hFE, 64'h0);
        chk("lh_signed", rsp_rdata, 64'hFFFFFFFFFFFFFFFE);

        issue(1'b1, 2'd2, 1'b0, 64'h10, 64'h12345678DEADBEEF);
        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        chk("store_fwd", rsp_rdata, 64'h17161514DEADBEEF);

        issue(1'b0, 2'd1, 1'b0, 64'h3, 64'h0);
        chk("misalign_err", 64'(rsp_err), 64'd1);
        issue(1'b1, 2'd3, 1'b0, 64'(DEPTH - 4), 64'hA5A5A5A5A5A5A5A5);
        chk("range_err", 64'(rsp_err), 64'd1);
        chk("err_cnt2", 64'(err_count), 64'd2);
        issue(1'b0, 2'd3, 1'b0, 64'(DEPTH - 8), 64'h0);
        chk("mem_untouched", rsp_rdata, 64'hFFFEFDFCFBFAF9F8);

        // Backpressure: response must hold while a new request waits.
        issue(1'b0, 2'd3, 1'b0, 64'h0, 64'h0);
        held = rsp_rdata;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h8; rsp_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold", rsp_rdata, held);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_new", rsp_rdata, 64'h0F0E0D0C0B0A0908);

        // Reset while a response is pending, with a store presented on the reset edge.
        issue(1'b0, 2'd3, 1'b0, 64'h0, 64'h0);
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(rsp_valid), 64'd0);
        chk("arst_rdata", rsp_rdata, 64'd0);
        chk("arst_cnt",   64'(err_count), 64'd0);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = 64'h0;
        req_wdata = 64'hAAAAAAAAAAAAAAAA;
        @(posedge clk); #1;
        chk("arst_drop", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; exp_cnt = 0;
        issue(1'b0, 2'd3, 1'b0, 64'h0, 64'h0);
        chk("post_rst", rsp_rdata, 64'h0706050403020100);

        for (int n = 0; n < 400; n++) begin
            logic [1:0]  sz;
            logic [63:0] a;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
            else a = 64'($urandom_range(0, DEPTH + 7));
            if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        for (int i = 0; i < DEPTH; i += 8) issue(1'b0, 2'd3, 1'b0, 64'(i), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
